issue_hazard_ctrl: RTL and testbench

// - Decode-side issue gate directly upstream of the decode->execute control pipeline register.
// - Scoreboards in-flight scalar/vector register writes and matrix-multiplier occupancy.
// - Each cycle decides: load decoded control word (issue) or inject an all-zero bubble; stalls fetch/decode.
// - Owns halt and synch_req sequencing via a small FSM.

---
 rtl/issue_hazard_ctrl_if.sv | 68 ++++++
 rtl/issue_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_issue_hazard_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_if.sv
// Issue gate bundle: decode-side request, writeback/completion events and issue decisions.
// Carries stall_cycles only when HAZARD_STATS_EN is defined.
interface issue_hazard_ctrl_if #(
   parameter int unsigned NSREG = 32,
   parameter int unsigned NVREG = 32
);
   localparam int unsigned SA_W = $clog2(NSREG);
   localparam int unsigned VA_W = $clog2(NVREG);

   logic            dec_valid;
   logic            dec_r_read1;
   logic            dec_r_read2;
   logic [SA_W-1:0] dec_sr1;
   logic [SA_W-1:0] dec_sr2;
   logic            dec_v_read1;
   logic            dec_v_read2;
   logic [VA_W-1:0] dec_vr1;
   logic [VA_W-1:0] dec_vr2;
   logic            dec_reg_wr_en;
   logic [SA_W-1:0] dec_sw;
   logic            dec_vec_wr_en;
   logic [VA_W-1:0] dec_vw;
   logic            dec_mm_en;
   logic            dec_halt;
   logic            dec_synch_req;
   logic            wb_reg_wr_en;
   logic [SA_W-1:0] wb_sw;
   logic            wb_vec_wr_en;
   logic [VA_W-1:0] wb_vw;
   logic            mm_done;
   logic            synch_ack;
   logic            ex_flush;
   logic            issue;
   logic            bubble;
   logic            stall_fetch;
   logic            halted;
`ifdef HAZARD_STATS_EN
   logic [31:0]     stall_cycles;
`endif

   // Decode/pipeline side: presents instructions and events, consumes decisions.
   modport master (
      output dec_valid, dec_r_read1, dec_r_read2, dec_sr1, dec_sr2,
      output dec_v_read1, dec_v_read2, dec_vr1, dec_vr2,
      output dec_reg_wr_en, dec_sw, dec_vec_wr_en, dec_vw,
      output dec_mm_en, dec_halt, dec_synch_req,
      output wb_reg_wr_en, wb_sw, wb_vec_wr_en, wb_vw,
      output mm_done, synch_ack, ex_flush,
`ifdef HAZARD_STATS_EN
      input  stall_cycles,
`endif
      input  issue, bubble, stall_fetch, halted
   );

   // Hazard controller side.
   modport slave (
      input  dec_valid, dec_r_read1, dec_r_read2, dec_sr1, dec_sr2,
      input  dec_v_read1, dec_v_read2, dec_vr1, dec_vr2,
      input  dec_reg_wr_en, dec_sw, dec_vec_wr_en, dec_vw,
      input  dec_mm_en, dec_halt, dec_synch_req,
      input  wb_reg_wr_en, wb_sw, wb_vec_wr_en, wb_vw,
      input  mm_done, synch_ack, ex_flush,
`ifdef HAZARD_STATS_EN
      output stall_cycles,
`endif
      output issue, bubble, stall_fetch, halted
   );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Decode-side issue gate: scoreboards in-flight scalar/vector writes and matrix-multiplier
// occupancy, chooses issue vs bubble each cycle, and sequences synch/halt.
// Optional macro HAZARD_STATS_EN adds a saturating stall-cycle counter.
module issue_hazard_ctrl #(
   parameter int unsigned NSREG = 32,
   parameter int unsigned NVREG = 32
) (
   input logic                clk,
   input logic                rst_n,
   issue_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StRun, StWaitSync, StDrain, StHalted} state_t;

   state_t           state_q, state_d;
   logic [NSREG-1:0] sb_q, sb_d, sb_eff, sb_clr, sb_set;
   logic [NVREG-1:0] vsb_q, vsb_d, vsb_eff, vsb_clr, vsb_set;
   logic             mm_busy_q, mm_busy_d, mm_busy_eff;
   logic             raw_hz, waw_hz, mm_hz, hazard;
   logic             run, issue_int, stall_ev;

   // Apply this cycle's writebacks first so a just-written source is not a hazard.
   always_comb begin
      sb_clr  = '0;
      vsb_clr = '0;
      if (bus.wb_reg_wr_en) sb_clr[bus.wb_sw] = 1'b1;
      if (bus.wb_vec_wr_en) vsb_clr[bus.wb_vw] = 1'b1;
      sb_eff    = sb_q & ~sb_clr;
      sb_eff[0] = 1'b0;  // r0 is hardwired, never pending
      vsb_eff   = vsb_q & ~vsb_clr;
      mm_busy_eff = mm_busy_q & ~bus.mm_done;
   end

   // Hazard detection and issue decision.
   always_comb begin
      raw_hz = (bus.dec_r_read1 & sb_eff[bus.dec_sr1]) |
               (bus.dec_r_read2 & sb_eff[bus.dec_sr2]) |
               (bus.dec_v_read1 & vsb_eff[bus.dec_vr1]) |
               (bus.dec_v_read2 & vsb_eff[bus.dec_vr2]);
      waw_hz = (bus.dec_reg_wr_en & sb_eff[bus.dec_sw]) |
               (bus.dec_vec_wr_en & vsb_eff[bus.dec_vw]);
      mm_hz  = bus.dec_mm_en & mm_busy_eff;
      hazard = raw_hz | waw_hz | mm_hz;
      run       = (state_q == StRun);
      issue_int = bus.dec_valid & run & ~hazard & ~bus.ex_flush;
      stall_ev  = bus.dec_valid & hazard & run & ~bus.ex_flush;
   end

   assign bus.issue       = issue_int;
   assign bus.bubble      = ~issue_int;
   assign bus.stall_fetch = stall_ev | ~run;
   assign bus.halted      = (state_q == StHalted);

   // Scoreboard next state: sets from the issuing op override same-cycle clears.
   always_comb begin
      sb_set  = '0;
      vsb_set = '0;
      if (issue_int && bus.dec_reg_wr_en && (bus.dec_sw != '0)) sb_set[bus.dec_sw] = 1'b1;
      if (issue_int && bus.dec_vec_wr_en) vsb_set[bus.dec_vw] = 1'b1;
      sb_d      = sb_eff | sb_set;
      vsb_d     = vsb_eff | vsb_set;
      mm_busy_d = mm_busy_eff | (issue_int & bus.dec_mm_en);
   end

   // Synch/halt sequencing; halt takes priority when both are issued together.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (issue_int && bus.dec_halt) state_d = StDrain;
            else if (issue_int && bus.dec_synch_req) state_d = StWaitSync;
         end
         StWaitSync: begin
            if (bus.synch_ack) state_d = StRun;
         end
         StDrain: begin
            if ((sb_eff == '0) && (vsb_eff == '0) && !mm_busy_eff) state_d = StHalted;
         end
         StHalted: state_d = StHalted;
      endcase
   end

   // State and scoreboard registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRun;
         sb_q      <= '0;
         vsb_q     <= '0;
         mm_busy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sb_q      <= sb_d;
         vsb_q     <= vsb_d;
         mm_busy_q <= mm_busy_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of cycles a valid instruction was held by a hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt_q;
`else
   // Stall statistics not built.
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed, table-driven bench for issue_hazard_ctrl.
module tb_issue_hazard_ctrl;

   logic clk;
   logic rst_n;

   issue_hazard_ctrl_if #(.NSREG(32), .NVREG(32)) bus ();

   issue_hazard_ctrl #(.NSREG(32), .NVREG(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus plus expected issue/stall_fetch/halted (bubble = ~issue).
   typedef struct {
      logic       dv;
      logic       rr1;
      logic [4:0] sr1;
      logic       rr2;
      logic [4:0] sr2;
      logic       rw;
      logic [4:0] sw;
      logic       vr;
      logic [4:0] vreg;
      logic       vwr;
      logic       mm;
      logic       hlt;
      logic       syn;
      logic       wbr;
      logic [4:0] wbs;
      logic       wbv;
      logic       done;
      logic       ack;
      logic       fl;
      logic       e_iss;
      logic       e_stl;
      logic       e_hlt;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;
   vec_t tbl [38];
   vec_t hv;

   task automatic chk(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic apply(input vec_t v);
      bus.dec_valid     = v.dv;
      bus.dec_r_read1   = v.rr1;
      bus.dec_sr1       = v.sr1;
      bus.dec_r_read2   = v.rr2;
      bus.dec_sr2       = v.sr2;
      bus.dec_reg_wr_en = v.rw;
      bus.dec_sw        = v.sw;
      bus.dec_v_read1   = v.vr;
      bus.dec_vr1       = v.vreg;
      bus.dec_v_read2   = 1'b0;
      bus.dec_vr2       = '0;
      bus.dec_vec_wr_en = v.vwr;
      bus.dec_vw        = v.vreg;
      bus.dec_mm_en     = v.mm;
      bus.dec_halt      = v.hlt;
      bus.dec_synch_req = v.syn;
      bus.wb_reg_wr_en  = v.wbr;
      bus.wb_sw         = v.wbs;
      bus.wb_vec_wr_en  = v.wbv;
      bus.wb_vw         = v.vreg;
      bus.mm_done       = v.done;
      bus.synch_ack     = v.ack;
      bus.ex_flush      = v.fl;
   endtask

   // Drive a row just after a rising edge, check mid-cycle, then advance one clock.
   task automatic run_row(input string name, input vec_t v);
      apply(v);
      #2;
      chk({name, ".issue"}, bus.issue, v.e_iss);
      chk({name, ".bubble"}, bus.bubble, ~v.e_iss);
      chk({name, ".stall"}, bus.stall_fetch, v.e_stl);
      chk({name, ".halted"}, bus.halted, v.e_hlt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          dv rr1 sr1 rr2 sr2 rw sw vr vreg vwr mm hlt syn wbr wbs wbv done ack fl  iss stl hlt
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // idle
      tbl[1]  = '{1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r5
      tbl[2]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // rd r5 RAW
      tbl[3]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0}; // wb r5 bypass
      tbl[4]  = '{1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r7
      tbl[5]  = '{1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0}; // wr r7 + wb r7
      tbl[6]  = '{1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // set won
      tbl[7]  = '{1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0};
      tbl[8]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r0
      tbl[9]  = '{1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // r0 free
      tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // mm
      tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // mm busy
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0}; // done issues
      tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // re-set won
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr v4
      tbl[18] = '{1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // rd v4
      tbl[19] = '{1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0}; // wb v4
      tbl[20] = '{1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r9
      tbl[21] = '{1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0}; // flush
      tbl[22] = '{1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // r9 kept
      tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0};
      tbl[24] = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r3
      tbl[25] = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // WAW
      tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0};
      tbl[27] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // synch
      tbl[28] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[29] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[30] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0}; // ack
      tbl[31] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // back in run
      tbl[32] = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // wr r3
      tbl[33] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}; // halt
      tbl[34] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // drain
      tbl[35] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0}; // wb r3
      tbl[36] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1}; // halted
      tbl[37] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1}; // sticky

      // Reset state
      rst_n = 1'b0;
      apply(tbl[0]);
      #12;
      chk("rst.issue", bus.issue, 1'b0);
      chk("rst.bubble", bus.bubble, 1'b1);
      chk("rst.stall", bus.stall_fetch, 1'b0);
      chk("rst.halted", bus.halted, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 38; i++) run_row($sformatf("row%0d", i), tbl[i]);

      // Reset leaves HALTED
      rst_n = 1'b0;
      apply(tbl[0]);
      #2;
      chk("halt_rst.halted", bus.halted, 1'b0);
      chk("halt_rst.stall", bus.stall_fetch, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Async reset in the middle of WAIT_SYNC drops pending r5
      run_row("h_wr5", tbl[1]);
      run_row("h_sync", tbl[27]);
      hv = tbl[28];
      apply(hv);
      #2;
      chk("h_wait.stall", bus.stall_fetch, 1'b1);
      chk("h_wait.issue", bus.issue, 1'b0);
      apply(tbl[0]);
      rst_n = 1'b0;
      #1;
      chk("h_rst.stall", bus.stall_fetch, 1'b0);
      chk("h_rst.halted", bus.halted, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      hv = tbl[2];
      hv.e_iss = 1'b1;
      hv.e_stl = 1'b0;
      run_row("h_rd5_after_rst", hv);

      // Halt and synch together: halt wins, drains straight to HALTED
      hv = tbl[33];
      hv.syn = 1'b1;
      run_row("h_both", hv);
      run_row("h_both_drain", tbl[34]);
      run_row("h_both_halted", tbl[36]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
